// File: rtl/hcu_dispatch.sv
// hcu_dispatch: assigns ingress hash packets to a bank of NUM_HCU hash compute
// units (round-robin over free cores), streams each packet into its core and
// returns the digests on one egress stream in strict dispatch order.
//
// Ports:
//   axis_aclk, axis_reset      clock, asynchronous active-high reset
//   s_axis_*                   ingress message stream (tdata/tuser/tvalid/tready/tlast)
//   hcu_s_*                    broadcast data/tuser/tlast, one-hot tvalid, per-core tready
//   hcu_m_*                    per-core digest slices, tvalid in, tready out
//   m_axis_*                   egress digest stream, single beat per digest
//   busy                       core allocated and digest not yet collected
//   pkt_dispatched             wrapping count of packets dispatched
//   dig_returned               wrapping count of digests returned
module hcu_dispatch #(
    parameter int unsigned NUM_HCU           = 4,
    parameter int unsigned S_AXIS_DATA_WIDTH = 64,
    parameter int unsigned M_AXIS_DATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH       = 128,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_reset,

    input  logic [S_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                 s_axis_tuser,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,

    output logic [S_AXIS_DATA_WIDTH-1:0]           hcu_s_tdata,
    output logic [TUSER_WIDTH-1:0]                 hcu_s_tuser,
    output logic                                   hcu_s_tlast,
    output logic [NUM_HCU-1:0]                     hcu_s_tvalid,
    input  logic [NUM_HCU-1:0]                     hcu_s_tready,

    input  logic [NUM_HCU*M_AXIS_DATA_WIDTH-1:0]   hcu_m_tdata,
    input  logic [NUM_HCU*TUSER_WIDTH-1:0]         hcu_m_tuser,
    input  logic [NUM_HCU-1:0]                     hcu_m_tvalid,
    output logic [NUM_HCU-1:0]                     hcu_m_tready,

    output logic [M_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,

    output logic [NUM_HCU-1:0]                     busy,
    output logic [CNT_WIDTH-1:0]                   pkt_dispatched,
    output logic [CNT_WIDTH-1:0]                   dig_returned
);

    localparam int unsigned IDX_W = (NUM_HCU > 1) ? $clog2(NUM_HCU) : 1;
    localparam int unsigned OCC_W = $clog2(NUM_HCU + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HCU - 1);

    typedef enum logic {D_IDLE, D_STREAM} dstate_t;
    typedef enum logic {C_WAIT, C_OUT}    cstate_t;

    dstate_t dstate, dstate_nxt;
    cstate_t cstate, cstate_nxt;

    logic [IDX_W-1:0] sel, sel_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [NUM_HCU-1:0] busy_nxt;

    // order FIFO of core indices, oldest dispatch at rd_ptr
    logic [IDX_W-1:0] order_mem [NUM_HCU];
    logic [IDX_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [IDX_W-1:0] head;
    logic             push, pop;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    logic                         m_valid_nxt;
    logic                         ret_inc;
    logic [M_AXIS_DATA_WIDTH-1:0] head_tdata;
    logic [TUSER_WIDTH-1:0]       head_tuser;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] x);
        return (x == LAST_IDX) ? '0 : x + IDX_W'(1);
    endfunction

    // payload is broadcast; only the selected core sees tvalid
    assign hcu_s_tdata = s_axis_tdata;
    assign hcu_s_tuser = s_axis_tuser;
    assign hcu_s_tlast = s_axis_tlast;

    assign head = order_mem[rd_ptr];

    // first free core at or after rr_ptr, wrapping modulo NUM_HCU
    always_comb begin : free_search
        logic [IDX_W-1:0] cand;
        free_found = 1'b0;
        free_idx   = '0;
        cand       = rr_ptr;
        for (int unsigned k = 0; k < NUM_HCU; k++) begin
            if (!free_found && !busy[cand]) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
            cand = inc_idx(cand);
        end
    end

    // digest slice of the core at the FIFO head
    always_comb begin
        head_tdata = '0;
        head_tuser = '0;
        for (int unsigned i = 0; i < NUM_HCU; i++) begin
            if (head == IDX_W'(i)) begin
                head_tdata = hcu_m_tdata[i*M_AXIS_DATA_WIDTH +: M_AXIS_DATA_WIDTH];
                head_tuser = hcu_m_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            end
        end
    end

    // dispatch FSM: next state and stream steering
    always_comb begin
        dstate_nxt    = dstate;
        sel_nxt       = sel;
        rr_ptr_nxt    = rr_ptr;
        s_axis_tready = 1'b0;
        hcu_s_tvalid  = '0;
        push          = 1'b0;
        case (dstate)
            D_IDLE: begin
                // selection cycle only; no beat is consumed here
                if (s_axis_tvalid && free_found) begin
                    sel_nxt    = free_idx;
                    push       = 1'b1;
                    dstate_nxt = D_STREAM;
                end
            end
            D_STREAM: begin
                hcu_s_tvalid[sel] = s_axis_tvalid;
                s_axis_tready     = hcu_s_tready[sel];
                if (s_axis_tvalid && hcu_s_tready[sel] && s_axis_tlast) begin
                    dstate_nxt = D_IDLE;
                    rr_ptr_nxt = inc_idx(sel);
                end
            end
            default: dstate_nxt = D_IDLE;
        endcase
    end

    // collect FSM: pull the head core's digest, hold it until egress accepts
    always_comb begin
        cstate_nxt   = cstate;
        pop          = 1'b0;
        hcu_m_tready = '0;
        m_valid_nxt  = m_axis_tvalid;
        ret_inc      = 1'b0;
        case (cstate)
            C_WAIT: begin
                if ((occ != '0) && hcu_m_tvalid[head]) begin
                    pop                = 1'b1;
                    hcu_m_tready[head] = 1'b1;
                    m_valid_nxt        = 1'b1;
                    cstate_nxt         = C_OUT;
                end
            end
            C_OUT: begin
                if (m_axis_tready) begin
                    m_valid_nxt = 1'b0;
                    ret_inc     = 1'b1;
                    cstate_nxt  = C_WAIT;
                end
            end
            default: cstate_nxt = C_WAIT;
        endcase
    end

    // set and clear always target different cores: a pushed core was free,
    // the popped head core was busy
    always_comb begin
        busy_nxt = busy;
        if (push) busy_nxt[free_idx] = 1'b1;
        if (pop)  busy_nxt[head]     = 1'b0;
    end

    // state, pointers, busy map and counters
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            dstate         <= D_IDLE;
            cstate         <= C_WAIT;
            sel            <= '0;
            rr_ptr         <= '0;
            busy           <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            pkt_dispatched <= '0;
            dig_returned   <= '0;
        end else begin
            dstate <= dstate_nxt;
            cstate <= cstate_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
            busy   <= busy_nxt;
            if (push) begin
                wr_ptr         <= inc_idx(wr_ptr);
                pkt_dispatched <= pkt_dispatched + CNT_WIDTH'(1);
            end
            if (pop) rd_ptr <= inc_idx(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (ret_inc) dig_returned <= dig_returned + CNT_WIDTH'(1);
        end
    end

    // FIFO storage; contents are only meaningful below occ
    always_ff @(posedge axis_aclk) begin
        if (push) order_mem[wr_ptr] <= free_idx;
    end

    // egress registers
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid <= m_valid_nxt;
            m_axis_tlast  <= m_valid_nxt;
            if (pop) begin
                m_axis_tdata <= head_tdata;
                m_axis_tuser <= head_tuser;
            end
        end
    end

endmodule

// File: tb/tb_hcu_dispatch.sv
// Self-checking bench for hcu_dispatch: behavioural core models, a
// packet-level reference model, a directed table and randomized traffic.
module tb_hcu_dispatch;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 64;
    localparam int unsigned MW = 512;
    localparam int unsigned UW = 128;
    localparam int unsigned CW = 16;

    logic              axis_aclk;
    logic              axis_reset;
    logic [SW-1:0]     s_axis_tdata;
    logic [UW-1:0]     s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [SW-1:0]     hcu_s_tdata;
    logic [UW-1:0]     hcu_s_tuser;
    logic              hcu_s_tlast;
    logic [N-1:0]      hcu_s_tvalid;
    logic [N-1:0]      hcu_s_tready;
    logic [N*MW-1:0]   hcu_m_tdata;
    logic [N*UW-1:0]   hcu_m_tuser;
    logic [N-1:0]      hcu_m_tvalid;
    logic [N-1:0]      hcu_m_tready;
    logic [MW-1:0]     m_axis_tdata;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [N-1:0]      busy;
    logic [CW-1:0]     pkt_dispatched;
    logic [CW-1:0]     dig_returned;

    hcu_dispatch #(
        .NUM_HCU(N), .S_AXIS_DATA_WIDTH(SW), .M_AXIS_DATA_WIDTH(MW),
        .TUSER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .axis_aclk(axis_aclk), .axis_reset(axis_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .hcu_s_tdata(hcu_s_tdata), .hcu_s_tuser(hcu_s_tuser),
        .hcu_s_tlast(hcu_s_tlast), .hcu_s_tvalid(hcu_s_tvalid),
        .hcu_s_tready(hcu_s_tready),
        .hcu_m_tdata(hcu_m_tdata), .hcu_m_tuser(hcu_m_tuser),
        .hcu_m_tvalid(hcu_m_tvalid), .hcu_m_tready(hcu_m_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy), .pkt_dispatched(pkt_dispatched), .dig_returned(dig_returned)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    typedef struct { int id; int len; int lat; logic [UW-1:0] user; } pkt_t;
    typedef struct { int len; int lat; int exp_core; } vec_t;

    // stimulus / environment state
    pkt_t src_q[$];
    int   src_beat;
    bit   src_hold;
    int   src_pct, crdy_pct, mrdy_pct;
    int   pkt_lat  [0:1023];
    int   pkt_core [0:1023];
    int   core_pid [N];
    int   core_nbeat [N];
    int   core_timer [N];
    int   core_dpid [N];
    bit   core_dv [N];
    int   next_id;

    // reference model: packet-level view of cores, order and counters
    logic [N-1:0] m_busy;
    int   m_rr;
    bit   m_in_pkt;
    int   m_cur;
    int   m_order[$];
    int   m_pidq[$];
    bit   m_out_pend;
    int   m_out_pid;
    int   m_disp, m_ret;

    int   n_pass, n_total;
    vec_t vecs [6];
    logic [MW-1:0] held_d;
    logic [UW-1:0] held_u;
    logic [CW-1:0] ret0;
    int   base, wait_n, rst_id;

    function automatic logic [MW-1:0] dig(input int pid);
        return {16{32'(pid) ^ 32'h5A5A_1234}};
    endfunction

    function automatic logic [UW-1:0] duser(input int pid);
        return {4{32'(pid) ^ 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reset_env();
        src_q.delete();
        src_beat = 0; src_hold = 0;
        for (int c = 0; c < N; c++) begin
            core_pid[c] = 0; core_nbeat[c] = 0; core_timer[c] = -1;
            core_dpid[c] = 0; core_dv[c] = 0;
        end
        m_busy = '0; m_rr = 0; m_in_pkt = 0; m_cur = 0;
        m_order.delete(); m_pidq.delete();
        m_out_pend = 0; m_out_pid = 0; m_disp = 0; m_ret = 0;
    endtask

    task automatic add_pkt(input int len, input int lat);
        pkt_t p;
        p.id = next_id; p.len = len; p.lat = lat;
        p.user = {$urandom, $urandom, $urandom, $urandom};
        pkt_lat[next_id & 1023] = lat;
        pkt_core[next_id & 1023] = -1;
        src_q.push_back(p);
        next_id++;
    endtask

    task automatic drive_inputs();
        if (src_q.size() > 0) begin
            s_axis_tvalid = src_hold ? 1'b1 : ($urandom_range(0, 99) < src_pct);
            s_axis_tdata  = {32'(src_q[0].id), 32'(src_beat)};
            s_axis_tuser  = src_q[0].user;
            s_axis_tlast  = (src_beat == src_q[0].len - 1);
        end else begin
            s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
        end
        for (int c = 0; c < N; c++) begin
            hcu_s_tready[c] = ($urandom_range(0, 99) < crdy_pct);
            hcu_m_tvalid[c] = core_dv[c];
            hcu_m_tdata[c*MW +: MW] = core_dv[c] ? dig(core_dpid[c]) : '0;
            hcu_m_tuser[c*UW +: UW] = core_dv[c] ? duser(core_dpid[c]) : '0;
        end
        m_axis_tready = ($urandom_range(0, 99) < mrdy_pct);
    endtask

    // sampled mid-cycle: predict DUT outputs, then advance model and environment
    task automatic check_and_update();
        logic [N-1:0] exp_hv, exp_mr;
        logic exp_rdy;
        int fsel, head, disp_pid;
        bit disp, beat_m, pop, out_hs;
        exp_hv = '0; exp_mr = '0; exp_rdy = 1'b0;
        fsel = -1; head = 0; disp_pid = 0;
        disp = 0; beat_m = 0; pop = 0;
        if (!m_in_pkt) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (fsel < 0 && !m_busy[c]) fsel = c;
            end
            disp = s_axis_tvalid && (fsel >= 0);
            if (disp) disp_pid = src_q[0].id;
        end else begin
            exp_hv[m_cur] = s_axis_tvalid;
            exp_rdy = hcu_s_tready[m_cur];
            beat_m = s_axis_tvalid && hcu_s_tready[m_cur];
            chk("hcu_s_tdata", hcu_s_tdata, s_axis_tdata);
            chk("hcu_s_tuser", hcu_s_tuser, s_axis_tuser);
            chk("hcu_s_tlast", hcu_s_tlast, s_axis_tlast);
        end
        chk("s_axis_tready", s_axis_tready, exp_rdy);
        chk("hcu_s_tvalid", hcu_s_tvalid, exp_hv);
        if (!m_out_pend && m_order.size() > 0 && core_dv[m_order[0]]) begin
            head = m_order[0]; exp_mr[head] = 1'b1; pop = 1;
        end
        chk("hcu_m_tready", hcu_m_tready, exp_mr);
        chk("m_axis_tvalid", m_axis_tvalid, m_out_pend);
        chk("m_axis_tlast", m_axis_tlast, m_out_pend);
        if (m_out_pend) begin
            chk("m_axis_tdata", m_axis_tdata, dig(m_out_pid));
            chk("m_axis_tuser", m_axis_tuser, duser(m_out_pid));
        end
        chk("busy", busy, m_busy);
        chk("pkt_dispatched", pkt_dispatched, CW'(m_disp));
        chk("dig_returned", dig_returned, CW'(m_ret));
        out_hs = m_out_pend && m_axis_tready;

        // model update (effects of the coming edge)
        if (out_hs) begin m_out_pend = 0; m_ret++; end
        if (pop) begin
            m_busy[head] = 1'b0;
            void'(m_order.pop_front());
            m_out_pend = 1; m_out_pid = m_pidq.pop_front();
        end
        if (disp) begin
            m_busy[fsel] = 1'b1; m_order.push_back(fsel); m_pidq.push_back(disp_pid);
            m_disp++; m_in_pkt = 1; m_cur = fsel;
        end
        if (beat_m && s_axis_tlast) begin m_in_pkt = 0; m_rr = (m_cur + 1) % N; end

        // environment: source and cores react to the actual DUT handshakes
        if (s_axis_tvalid && s_axis_tready && src_q.size() > 0) begin
            src_hold = 0; src_beat++;
            if (src_beat == src_q[0].len) begin void'(src_q.pop_front()); src_beat = 0; end
        end else begin
            src_hold = s_axis_tvalid;
        end
        for (int c = 0; c < N; c++) begin
            if (core_dv[c] && hcu_m_tready[c]) core_dv[c] = 0;
            if (core_timer[c] > 0) core_timer[c]--;
            else if (core_timer[c] == 0) begin
                core_dv[c] = 1; core_dpid[c] = core_pid[c]; core_timer[c] = -1;
            end
            if (hcu_s_tvalid[c] && hcu_s_tready[c]) begin
                int pid, bt;
                pid = int'(hcu_s_tdata[63:32]); bt = int'(hcu_s_tdata[31:0]);
                if (core_nbeat[c] == 0) core_pid[c] = pid;
                chk("core_rx_seq", {32'(pid), 32'(bt)}, {32'(core_pid[c]), 32'(core_nbeat[c])});
                core_nbeat[c]++;
                if (hcu_s_tlast) begin
                    core_nbeat[c] = 0;
                    core_timer[c] = pkt_lat[pid & 1023];
                    pkt_core[pid & 1023] = c;
                end
            end
        end
    endtask

    task automatic cycle();
        drive_inputs();
        @(negedge axis_aclk);
        check_and_update();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (dig_returned != CW'(target) && n < budget) begin cycle(); n++; end
        chk(name, dig_returned, CW'(target));
    endtask

    initial begin
        n_pass = 0; n_total = 0; next_id = 0;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 0;
        hcu_s_tready = '0; hcu_m_tvalid = '0; hcu_m_tdata = '0; hcu_m_tuser = '0;
        m_axis_tready = 0;
        reset_env();
        src_pct = 100; crdy_pct = 100; mrdy_pct = 100;
        axis_reset = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_hcu_s_tvalid", hcu_s_tvalid, '0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_busy", busy, '0);
        chk("rst_counts", {pkt_dispatched, dig_returned}, '0);
        axis_reset = 1'b0;

        // directed table: round-robin, out-of-order completion, all-busy stall
        vecs[0] = '{len: 1,  lat: 20, exp_core: 0};
        vecs[1] = '{len: 1,  lat: 5,  exp_core: 1};
        vecs[2] = '{len: 1,  lat: 30, exp_core: 2};
        vecs[3] = '{len: 1,  lat: 30, exp_core: 3};
        vecs[4] = '{len: 1,  lat: 2,  exp_core: 0};
        vecs[5] = '{len: 16, lat: 3,  exp_core: 1};
        base = next_id;
        for (int i = 0; i < 6; i++) add_pkt(vecs[i].len, vecs[i].lat);
        run_until(6, 600, "table_drain");
        for (int i = 0; i < 6; i++)
            chk($sformatf("table_core_pkt%0d", i), pkt_core[base + i], vecs[i].exp_core);
        chk("table_busy_idle", busy, '0);
        chk("table_dispatched", pkt_dispatched, CW'(6));

        // tvalid gaps, ready gaps and one-beat packets
        src_pct = 50; crdy_pct = 60;
        for (int i = 0; i < 6; i++) add_pkt((i % 2 == 0) ? 1 : 4, 1);
        run_until(12, 800, "gap_drain");

        // egress backpressure for 10 cycles
        src_pct = 100; crdy_pct = 100; mrdy_pct = 0;
        add_pkt(2, 0);
        add_pkt(1, 0);
        wait_n = 0;
        while (!m_axis_tvalid && wait_n < 100) begin cycle(); wait_n++; end
        chk("bp_valid_seen", m_axis_tvalid, 1'b1);
        held_d = m_axis_tdata; held_u = m_axis_tuser; ret0 = dig_returned;
        repeat (10) begin
            cycle();
            chk("bp_tdata_stable", m_axis_tdata, held_d);
            chk("bp_tuser_stable", m_axis_tuser, held_u);
            chk("bp_next_core_held", hcu_m_tready, '0);
            chk("bp_count_hold", dig_returned, ret0);
        end
        mrdy_pct = 100;
        cycle();
        chk("bp_release_once", dig_returned, ret0 + CW'(1));
        cycle();
        chk("bp_release_once_2", dig_returned, ret0 + CW'(1));
        run_until(14, 200, "bp_drain");

        // randomized traffic against the model
        src_pct = 70; crdy_pct = 75; mrdy_pct = 60;
        for (int i = 0; i < 40; i++)
            add_pkt(($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 12)));
        run_until(54, 6000, "random_drain");

        // asynchronous reset in the middle of a 16-beat packet
        src_pct = 100; crdy_pct = 100; mrdy_pct = 100;
        add_pkt(16, 3);
        wait_n = 0;
        while (src_beat != 7 && wait_n < 100) begin cycle(); wait_n++; end
        chk("rst_mid_beat7", 32'(src_beat), 32'd7);
        #2;
        axis_reset = 1'b1;
        #1;
        chk("amid_s_tready", s_axis_tready, 1'b0);
        chk("amid_hcu_s_tvalid", hcu_s_tvalid, '0);
        chk("amid_hcu_m_tready", hcu_m_tready, '0);
        chk("amid_m_tvalid_tlast", {m_axis_tvalid, m_axis_tlast}, 2'b00);
        chk("amid_m_tdata", m_axis_tdata, '0);
        chk("amid_m_tuser", m_axis_tuser, '0);
        chk("amid_busy", busy, '0);
        chk("amid_counts", {pkt_dispatched, dig_returned}, '0);
        @(posedge axis_aclk);
        #3;
        axis_reset = 1'b0;
        reset_env();
        rst_id = next_id;
        add_pkt(3, 1);
        run_until(1, 100, "post_reset_drain");
        chk("post_reset_core0", pkt_core[rst_id & 1023], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hcu_dispatch.md
Name: hcu_dispatch

Overview:
- Sits between the hash ingress AXI-Stream and a bank of NUM_HCU hash compute units (hcu).
- Assigns each incoming message packet (s_axis_tvalid ... tlast) to a free hcu, chosen round-robin.
- Streams the whole packet into that core.
- Collects the resulting digests and returns them on a single egress stream, in strict dispatch order.

Parameters:
- NUM_HCU, 4: number of attached hcu instances; 2..8.
- S_AXIS_DATA_WIDTH, 64: message word width.
- M_AXIS_DATA_WIDTH, 512: digest width.
- TUSER_WIDTH, 128: tuser width on both sides.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- axis_aclk  in  1  clock
- axis_reset  in  1  asynchronous active-high reset
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  message word
- s_axis_tuser  in  TUSER_WIDTH  sideband; carries sha_type
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- hcu_s_tdata  out  S_AXIS_DATA_WIDTH  broadcast to all cores
- hcu_s_tuser  out  TUSER_WIDTH  broadcast
- hcu_s_tlast  out  1  broadcast
- hcu_s_tvalid  out  NUM_HCU  one-hot per core
- hcu_s_tready  in  NUM_HCU
- hcu_m_tdata  in  NUM_HCU*M_AXIS_DATA_WIDTH  core i digest at slice i
- hcu_m_tuser  in  NUM_HCU*TUSER_WIDTH
- hcu_m_tvalid  in  NUM_HCU
- hcu_m_tready  out  NUM_HCU
- m_axis_tdata  out  M_AXIS_DATA_WIDTH  digest
- m_axis_tuser  out  TUSER_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- busy  out  NUM_HCU  core allocated, digest not yet collected
- pkt_dispatched  out  CNT_WIDTH  wrapping count of packets dispatched
- dig_returned  out  CNT_WIDTH  wrapping count of digests returned

Behaviour:

Reset (asynchronous, axis_reset=1):
- Dispatch FSM goes to IDLE; collect FSM goes to WAIT.
- busy, rr_ptr, sel, order FIFO pointers and both counters are cleared.
- s_axis_tready, hcu_s_tvalid, hcu_m_tready, m_axis_tvalid and m_axis_tlast are 0; m_axis_tdata and m_axis_tuser are 0.
- Reset mid-packet abandons the packet. Cores share the same reset.

Dispatch FSM:
- IDLE:
  - s_axis_tready=0.
  - If s_axis_tvalid and any busy bit is clear: sel <= first free index searching from rr_ptr upward, modulo NUM_HCU; busy[sel] <= 1; push sel into the order FIFO; pkt_dispatched++; next state STREAM.
  - The selection cycle consumes no beat.
- STREAM:
  - hcu_s_tvalid[sel] = s_axis_tvalid; all other bits are 0.
  - s_axis_tready = hcu_s_tready[sel], combinational pass-through with zero latency.
  - Data, tuser and tlast pass through combinationally.
  - Beat handshake with s_axis_tlast=1: next state IDLE; rr_ptr <= (sel+1) mod NUM_HCU.
  - tvalid gaps mid-packet are forwarded unchanged.
  - A one-beat packet (tlast on the first beat) is legal.
- Back-to-back packets incur one IDLE cycle each.

Order FIFO:
- Depth NUM_HCU; holds core indices.
- It cannot overflow, because a push requires a free core and entries ≤ busy cores.

Collect FSM:
- WAIT:
  - Active when the FIFO is non-empty and hcu_m_tvalid[head] is 1.
  - hcu_m_tready[head]=1 for that one cycle.
  - Registers hcu_m_tdata and hcu_m_tuser slice [head] into the m_axis regs.
  - Pops the FIFO; busy[head] <= 0.
  - m_axis_tvalid and m_axis_tlast <= 1; next state OUT.
- OUT:
  - Holds the output until m_axis_tready.
  - On handshake: m_axis_tvalid and m_axis_tlast <= 0; dig_returned++; next state WAIT.
- Latency: 1 cycle from core valid to m_axis_tvalid. Maximum throughput: 1 digest per 2 cycles.
- Digests from non-head cores are held by those cores (hcu_m_tready=0) until their turn, so output order equals dispatch order.
- m_axis_tlast equals m_axis_tvalid; each digest is a single beat.

Simultaneous events:
- A busy clear (collect) and a busy set (dispatch) in the same cycle act on different cores.
- A core freed in cycle N is eligible for selection from cycle N+1.
- FIFO push and pop in the same cycle: the occupancy count is unchanged.

All busy:
- IDLE stalls with s_axis_tready=0 until a digest is collected.

Counters:
- Wrap modulo 2^CNT_WIDTH.

Test Plan:
- Single packet: 16 beats, sha_type=SHA-256, NUM_HCU=4 -> routed only to core 0; busy=0001 during the packet. After core 0 returns its digest, m_axis_tvalid rises 1 cycle later; busy=0000; pkt_dispatched=1; dig_returned=1.
- Round-robin: 5 back-to-back one-block packets with all cores idle -> assigned to cores 0,1,2,3 in order. Packet 5 stalls in IDLE (s_axis_tready=0) until the first digest pops, then goes to core 0.
- Out-of-order completion: core 1 raises digest valid before core 0 -> hcu_m_tready[1] stays 0 until core 0's digest has handshaked. m_axis output order is core 0 then core 1.
- Backpressure: hold m_axis_tready=0 for 10 cycles -> m_axis_tdata and m_axis_tuser stay stable with m_axis_tvalid=1. The next core's hcu_m_tready stays 0. dig_returned increments exactly once after release.
- Stream gaps and short packet: s_axis_tvalid toggles every other cycle -> hcu_s_tvalid[sel] mirrors it. A one-beat tlast packet returns to IDLE next cycle, with rr_ptr advanced.
- Asynchronous reset asserted mid-packet (beat 7 of 16) -> all outputs go to 0 immediately without a clock edge; busy=0. The first packet after release is dispatched to core 0.
